ccu_snoop_collector: RTL
========================

CCU_SNOOP_COLLECTOR -- requirements
Module: ccu_snoop_collector

Interface
REQ-001 SHALL have parameter NB_CORES, default culsans_pkg::NB_CORES (2), the number of snooped cores.
REQ-002 SHALL have parameter DataWidth, default 64, the CD beat width.
REQ-003 SHALL have parameter LineBeats, default 2, the CD beats per cache line.
REQ-004 clk_i  in  1  sole clock; all state samples on rising edge.
REQ-005 rst_i  in  1  reset; asynchronous, active-high.
REQ-006 start_valid_i / start_ready_o  in/out  1  accept a new snoop transaction.
REQ-007 start_mask_i  in  NB_CORES  cores snooped in this transaction; the requester's bit is already cleared by upstream.
REQ-008 cr_valid_i / cr_ready_o  in/out  NB_CORES  per-core snoop-response handshake.
REQ-009 cr_resp_i  in  NB_CORES x 5  per-core CRRESP: [0] DataTransfer, [1] Error, [2] PassDirty, [3] IsShared, [4] WasUnique.
REQ-010 cd_valid_i / cd_ready_o  in/out  NB_CORES  per-core snoop-data handshake.
REQ-011 cd_data_i  in  NB_CORES x DataWidth  per-core CD beat.
REQ-012 cd_last_i  in  NB_CORES  last-beat flag of each core's CD stream.
REQ-013 done_valid_o / done_ready_i  out/in  1  merged result handshake.
REQ-014 data_avail_o, pass_dirty_o, is_shared_o, error_o  out  1 each  merged response flags.
REQ-015 line_o  out  LineBeats*DataWidth  captured line; beat 0 in the LSBs.

Function
REQ-016 SHALL implement FSM states IDLE, COLLECT_CR, COLLECT_CD, DONE.
REQ-017 IDLE: start_ready_o=1; on start_valid_i, latch start_mask_i into pend_cr and go to COLLECT_CR the next cycle.
REQ-018 A start with all-zero mask SHALL go directly to DONE with all flags 0.
REQ-019 COLLECT_CR: cr_ready_o[i]=pend_cr[i]; on each handshake, clear pend_cr[i], OR the Error/PassDirty/IsShared bits into the merged flags, and set pend_cd[i] if DataTransfer=1.
REQ-020 Simultaneous CR handshakes from several cores in one cycle SHALL all be accepted and merged.
REQ-021 When pend_cr becomes 0: go to COLLECT_CD if pend_cd is non-zero, else to DONE.
REQ-022 The data source SHALL be the lowest-index core with pend_cd set; data_avail_o=1 iff pend_cd was non-zero.
REQ-023 COLLECT_CD: cd_ready_o[i]=pend_cd[i] for every core; source beats are written to line_o slot beat_cnt, then beat_cnt increments; non-source cores' beats are drained and discarded.
REQ-024 On a handshake with cd_last_i[i]=1, SHALL clear pend_cd[i]; when pend_cd reaches 0, go to DONE.
REQ-025 Source beats beyond LineBeats SHALL be discarded and set error_o.
REQ-026 cd_last_i asserted before beat LineBeats-1 on the source SHALL set error_o.
REQ-027 cr_ready_o and cd_ready_o SHALL be 0 outside their own states and 0 for unmasked cores; CD beats arriving during COLLECT_CR SHALL stall, not be accepted.
REQ-028 DONE: done_valid_o=1 with outputs stable until done_ready_i; on handshake go to IDLE and clear the flags, pend_cr, pend_cd and beat_cnt.
REQ-029 start_ready_o SHALL be 0 in every state except IDLE; there is no start/done overlap.
REQ-030 Minimum latency is start accept -> done_valid_o in 2 cycles (one CR cycle, no data).
REQ-031 beat_cnt width SHALL be $clog2(LineBeats)+1 and SHALL saturate at LineBeats.

Reset
REQ-032 rst_i SHALL force state IDLE, pend_cr=0, pend_cd=0, beat_cnt=0, all flags=0 and line_o=0, asynchronously.
REQ-033 Out of reset: start_ready_o=1; done_valid_o, cr_ready_o and cd_ready_o all 0.
REQ-034 Reset mid-transaction SHALL abandon it; no done is produced and no handshakes complete after reset.

Verification
REQ-035 Clean miss: mask=2'b10; core1 CR=5'b01000 -> done 2 cycles after start with is_shared=1 and data_avail=0.
REQ-036 Dirty hit: mask=2'b11; both CR in the same cycle, core0=5'b00101, core1=5'b00000; core0 sends CD 0xA, 0xB (last) -> line_o=0x..B..A, pass_dirty=1, data_avail=1.
REQ-037 Dual data: both CR DataTransfer=1; core1 CD arrives first -> core1 stream drained, line_o from core0 only, done only after both last beats.
REQ-038 Protocol error: source cd_last_i on beat 0 -> error_o=1; the third beat of a three-beat stream is discarded and error_o=1.
REQ-039 Backpressure and reset: done_ready_i=0 for 5 cycles -> outputs stable; rst_i pulsed in COLLECT_CD -> IDLE immediately, no done_valid_o.

Source files
------------

// File: rtl/ccu_snoop_collector.sv
// Collects snoop responses (CR) and snoop data (CD) from the snooped cores,
// merges the response flags and captures one cache line from the lowest-index data source.
module ccu_snoop_collector #(
    parameter int unsigned NB_CORES  = 2,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned LineBeats = 2
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            start_valid_i,
    output logic                            start_ready_o,
    input  logic [NB_CORES-1:0]             start_mask_i,
    input  logic [NB_CORES-1:0]             cr_valid_i,
    output logic [NB_CORES-1:0]             cr_ready_o,
    input  logic [NB_CORES*5-1:0]           cr_resp_i,
    input  logic [NB_CORES-1:0]             cd_valid_i,
    output logic [NB_CORES-1:0]             cd_ready_o,
    input  logic [NB_CORES*DataWidth-1:0]   cd_data_i,
    input  logic [NB_CORES-1:0]             cd_last_i,
    output logic                            done_valid_o,
    input  logic                            done_ready_i,
    output logic                            data_avail_o,
    output logic                            pass_dirty_o,
    output logic                            is_shared_o,
    output logic                            error_o,
    output logic [LineBeats*DataWidth-1:0]  line_o
);

    localparam int unsigned CntW = $clog2(LineBeats) + 1;
    localparam int unsigned SrcW = (NB_CORES > 1) ? $clog2(NB_CORES) : 1;

    localparam logic [1:0] StIdle      = 2'd0;
    localparam logic [1:0] StCollectCr = 2'd1;
    localparam logic [1:0] StCollectCd = 2'd2;
    localparam logic [1:0] StDone      = 2'd3;

    logic [1:0]                     state_q, state_d;
    logic [NB_CORES-1:0]            pend_cr_q, pend_cr_d;
    logic [NB_CORES-1:0]            pend_cd_q, pend_cd_d;
    logic [CntW-1:0]                beat_cnt_q, beat_cnt_d;
    logic [SrcW-1:0]                src_q, src_d;
    logic [LineBeats*DataWidth-1:0] line_q, line_d;
    logic                           data_avail_q, data_avail_d;
    logic                           pass_dirty_q, pass_dirty_d;
    logic                           is_shared_q, is_shared_d;
    logic                           error_q, error_d;

    // WasUnique is carried on the CR channel but has no role in the merged result.
    logic unused_was_unique;
    always_comb begin
        unused_was_unique = 1'b0;
        for (int i = 0; i < NB_CORES; i++) begin
            unused_was_unique = unused_was_unique ^ cr_resp_i[i*5+4];
        end
    end

    always_comb begin
        state_d       = state_q;
        pend_cr_d     = pend_cr_q;
        pend_cd_d     = pend_cd_q;
        beat_cnt_d    = beat_cnt_q;
        src_d         = src_q;
        line_d        = line_q;
        data_avail_d  = data_avail_q;
        pass_dirty_d  = pass_dirty_q;
        is_shared_d   = is_shared_q;
        error_d       = error_q;
        start_ready_o = 1'b0;
        done_valid_o  = 1'b0;
        cr_ready_o    = '0;
        cd_ready_o    = '0;

        case (state_q)
            StIdle: begin
                start_ready_o = 1'b1;
                if (start_valid_i) begin
                    pend_cr_d = start_mask_i;
                    state_d   = (start_mask_i == '0) ? StDone : StCollectCr;
                end
            end

            StCollectCr: begin
                cr_ready_o = pend_cr_q;
                for (int i = 0; i < NB_CORES; i++) begin
                    if (cr_valid_i[i] && pend_cr_q[i]) begin
                        pend_cr_d[i] = 1'b0;
                        error_d      = error_d | cr_resp_i[i*5+1];
                        pass_dirty_d = pass_dirty_d | cr_resp_i[i*5+2];
                        is_shared_d  = is_shared_d | cr_resp_i[i*5+3];
                        if (cr_resp_i[i*5]) begin
                            pend_cd_d[i] = 1'b1;
                        end
                    end
                end
                if (pend_cr_d == '0) begin
                    if (pend_cd_d != '0) begin
                        state_d      = StCollectCd;
                        data_avail_d = 1'b1;
                        // Descending scan leaves the lowest pending index as the source.
                        for (int i = NB_CORES - 1; i >= 0; i--) begin
                            if (pend_cd_d[i]) begin
                                src_d = SrcW'(i);
                            end
                        end
                    end else begin
                        state_d = StDone;
                    end
                end
            end

            StCollectCd: begin
                cd_ready_o = pend_cd_q;
                for (int i = 0; i < NB_CORES; i++) begin
                    if (cd_valid_i[i] && pend_cd_q[i]) begin
                        if (SrcW'(i) == src_q) begin
                            if (beat_cnt_q < CntW'(LineBeats)) begin
                                for (int b = 0; b < LineBeats; b++) begin
                                    if (beat_cnt_q == CntW'(b)) begin
                                        line_d[b*DataWidth +: DataWidth] =
                                            cd_data_i[i*DataWidth +: DataWidth];
                                    end
                                end
                                beat_cnt_d = beat_cnt_q + CntW'(1);
                            end else begin
                                error_d = 1'b1;
                            end
                            if (cd_last_i[i] && (beat_cnt_q < CntW'(LineBeats - 1))) begin
                                error_d = 1'b1;
                            end
                        end
                        if (cd_last_i[i]) begin
                            pend_cd_d[i] = 1'b0;
                        end
                    end
                end
                if (pend_cd_d == '0) begin
                    state_d = StDone;
                end
            end

            StDone: begin
                done_valid_o = 1'b1;
                if (done_ready_i) begin
                    state_d      = StIdle;
                    pend_cr_d    = '0;
                    pend_cd_d    = '0;
                    beat_cnt_d   = '0;
                    data_avail_d = 1'b0;
                    pass_dirty_d = 1'b0;
                    is_shared_d  = 1'b0;
                    error_d      = 1'b0;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            pend_cr_q    <= '0;
            pend_cd_q    <= '0;
            beat_cnt_q   <= '0;
            src_q        <= '0;
            line_q       <= '0;
            data_avail_q <= 1'b0;
            pass_dirty_q <= 1'b0;
            is_shared_q  <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_cr_q    <= pend_cr_d;
            pend_cd_q    <= pend_cd_d;
            beat_cnt_q   <= beat_cnt_d;
            src_q        <= src_d;
            line_q       <= line_d;
            data_avail_q <= data_avail_d;
            pass_dirty_q <= pass_dirty_d;
            is_shared_q  <= is_shared_d;
            error_q      <= error_d;
        end
    end

    assign data_avail_o = data_avail_q;
    assign pass_dirty_o = pass_dirty_q;
    assign is_shared_o  = is_shared_q;
    assign error_o      = error_q;
    assign line_o       = line_q;

endmodule
